// File: rtl/estendedor_pkg.sv
// estendedor_pkg: shared state type and duration clamp for the pulse stretcher
package estendedor_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ALTO   = 2'd1,
        PAUSA  = 2'd2
    } estado_t;

    // A requested width of 0 would give no pulse at all; treat it as 1 cycle.
    function automatic logic [31:0] satura_duracao(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/estendedor_canal.sv
// estendedor_canal: one stretcher channel (FSM, width/gap counter, one-deep queue, loss flag)
//   clk, rst (async, active-high)
//   pulso          single-cycle event request
//   duracao        pulse width D (0 treated as 1), shared
//   retrig         1: event during ALTO extends the pulse, 0: queues it
//   limpa_perdido  synchronous clear of perdido
//   saida          registered stretched level
//   ocupado        registered: not idle or event pending
//   perdido        registered sticky: an event was dropped
module estendedor_canal
    import estendedor_pkg::*;
#(
    parameter int W         = 8,
    parameter int PAUSA_MIN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pulso,
    input  logic [W-1:0] duracao,
    input  logic         retrig,
    input  logic         limpa_perdido,
    output logic         saida,
    output logic         ocupado,
    output logic         perdido
);

    localparam logic [W-1:0] CARGA_PAUSA = W'(PAUSA_MIN - 1);

    estado_t      r_estado;
    logic [W-1:0] r_cnt;
    logic         r_pendente;
    logic         r_saida;
    logic         r_ocupado;
    logic         r_perdido;
    logic [W-1:0] w_carga;

    assign w_carga = W'(satura_duracao(32'(duracao)) - 32'd1);

    // The clear is written first so that any loss assignment later in the
    // same cycle overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado   <= OCIOSO;
            r_cnt      <= '0;
            r_pendente <= 1'b0;
            r_saida    <= 1'b0;
            r_ocupado  <= 1'b0;
            r_perdido  <= 1'b0;
        end else begin
            if (limpa_perdido)
                r_perdido <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (pulso) begin
                        r_estado  <= ALTO;
                        r_cnt     <= w_carga;
                        r_saida   <= 1'b1;
                        r_ocupado <= 1'b1;
                    end
                end
                ALTO: begin
                    if (pulso && retrig) begin
                        r_cnt <= w_carga;
                    end else begin
                        if (pulso) begin
                            if (r_pendente)
                                r_perdido <= 1'b1;
                            else
                                r_pendente <= 1'b1;
                        end
                        // cnt==0 ends the pulse before any decrement, so no wrap
                        if (r_cnt == '0) begin
                            r_estado <= PAUSA;
                            r_cnt    <= CARGA_PAUSA;
                            r_saida  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                PAUSA: begin
                    if (r_cnt == '0) begin
                        // An event arriving on the last gap cycle starts the
                        // next pulse directly instead of being stranded.
                        if (r_pendente || pulso) begin
                            r_estado   <= ALTO;
                            r_cnt      <= w_carga;
                            r_saida    <= 1'b1;
                            r_pendente <= 1'b0;
                            if (pulso && r_pendente)
                                r_perdido <= 1'b1;
                        end else begin
                            r_estado  <= OCIOSO;
                            r_ocupado <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (pulso) begin
                            if (r_pendente)
                                r_perdido <= 1'b1;
                            else
                                r_pendente <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_saida   <= 1'b0;
                    r_ocupado <= r_pendente;
                end
            endcase
        end
    end

    assign saida   = r_saida;
    assign ocupado = r_ocupado;
    assign perdido = r_perdido;

endmodule

// File: rtl/estendedor_pulso.sv
// estendedor_pulso: multi-channel pulse stretcher with mandatory low gap and one-deep queue
//   clk, rst (async, active-high)
//   pulso[CANAIS]   event requests
//   duracao[W]      pulse width, shared (0 treated as 1)
//   retrig          extend-on-event enable, shared
//   limpa_perdido   clears all perdido bits
//   saida[CANAIS]   stretched outputs
//   ocupado[CANAIS] channel active or event pending
//   perdido[CANAIS] sticky dropped-event flags
module estendedor_pulso
    import estendedor_pkg::*;
#(
    parameter int CANAIS    = 2,
    parameter int W         = 8,
    parameter int PAUSA_MIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CANAIS-1:0] pulso,
    input  logic [W-1:0]      duracao,
    input  logic              retrig,
    input  logic              limpa_perdido,
    output logic [CANAIS-1:0] saida,
    output logic [CANAIS-1:0] ocupado,
    output logic [CANAIS-1:0] perdido
);

    for (genvar g = 0; g < CANAIS; g++) begin : g_canal
        estendedor_canal #(
            .W         (W),
            .PAUSA_MIN (PAUSA_MIN)
        ) u_canal (
            .clk           (clk),
            .rst           (rst),
            .pulso         (pulso[g]),
            .duracao       (duracao),
            .retrig        (retrig),
            .limpa_perdido (limpa_perdido),
            .saida         (saida[g]),
            .ocupado       (ocupado[g]),
            .perdido       (perdido[g])
        );
    end

endmodule

// File: tb/tb_estendedor_pulso.sv
// tb_estendedor_pulso: directed self-checking bench for estendedor_pulso
module tb_estendedor_pulso;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pulso = 2'b00;
    logic [7:0] duracao = 8'd4;
    logic       retrig = 1'b0;
    logic       limpa_perdido = 1'b0;
    logic [1:0] saida;
    logic [1:0] ocupado;
    logic [1:0] perdido;

    int total = 0;
    int passou = 0;

    logic [31:0] s;
    logic [31:0] o;
    logic        viu_ch1;
    int          altos;

    estendedor_pulso #(.CANAIS(2), .W(8), .PAUSA_MIN(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .pulso         (pulso),
        .duracao       (duracao),
        .retrig        (retrig),
        .limpa_perdido (limpa_perdido),
        .saida         (saida),
        .ocupado       (ocupado),
        .perdido       (perdido)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs === esp)
            passou++;
        else
            $display("FAIL %s: got %b expected %b", tag, obs, esp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives channel 0 with padrao (MSB first, one bit per edge) and records
    // saida[0]/ocupado[0] sampled just after each of those edges.
    task automatic roda(input logic [31:0] padrao, input int n,
                        output logic [31:0] so, output logic [31:0] oo);
        so = '0;
        oo = '0;
        viu_ch1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            pulso = {1'b0, padrao[n-1-i]};
            tick();
            pulso = 2'b00;
            so = {so[30:0], saida[0]};
            oo = {oo[30:0], ocupado[0]};
            viu_ch1 = viu_ch1 | saida[1] | ocupado[1];
        end
    endtask

    initial begin
        repeat (2) tick();
        verifica("reset saida", 32'(saida), 32'd0);
        verifica("reset ocupado", 32'(ocupado), 32'd0);
        verifica("reset perdido", 32'(perdido), 32'd0);
        rst = 1'b0;
        tick();

        duracao = 8'd4;
        roda(32'b1000000, 7, s, o);
        verifica("single saida", s, 32'b1111000);
        verifica("single ocupado", o, 32'b1111100);
        verifica("single ch1 quiet", 32'(viu_ch1), 32'd0);

        duracao = 8'd0;
        roda(32'b100, 3, s, o);
        verifica("d0 saida", s, 32'b100);
        verifica("d0 ocupado", o, 32'b110);

        duracao = 8'd4;
        roda(32'b10100000000, 11, s, o);
        verifica("queued saida", s, 32'b11110111100);
        verifica("queued ocupado", o, 32'b11111111110);
        verifica("queued perdido", 32'(perdido), 32'd0);

        roda(32'b11100000000, 11, s, o);
        verifica("triple saida", s, 32'b11110111100);
        verifica("triple perdido", 32'(perdido), 32'b01);
        tick();
        verifica("perdido sticky", 32'(perdido), 32'b01);
        limpa_perdido = 1'b1;
        tick();
        limpa_perdido = 1'b0;
        verifica("limpa perdido", 32'(perdido), 32'd0);

        duracao = 8'd3;
        retrig = 1'b1;
        roda(32'b10100000, 8, s, o);
        verifica("retrig saida", s, 32'b11111000);
        retrig = 1'b0;
        tick();

        duracao = 8'd4;
        roda(32'b111, 3, s, o);
        verifica("pre-reset perdido", 32'(perdido), 32'b01);
        #2 rst = 1'b1;
        #1;
        verifica("async rst saida", 32'(saida), 32'd0);
        verifica("async rst ocupado", 32'(ocupado), 32'd0);
        verifica("async rst perdido", 32'(perdido), 32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        roda(32'b10000000, 8, s, o);
        verifica("post-reset saida", s, 32'b11110000);
        verifica("post-reset ocupado", o, 32'b11111000);

        duracao = 8'd255;
        pulso = 2'b10;
        tick();
        pulso = 2'b00;
        altos = 0;
        for (int i = 0; i < 260; i++) begin
            altos += int'(saida[1]);
            tick();
        end
        verifica("max width ch1", 32'(altos), 32'd255);
        verifica("max width ch0 quiet", 32'(saida[0]), 32'd0);

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end

endmodule

// File: doc/estendedor_pulso.md
# estendedor_pulso

Multi-channel pulse stretcher, the opposite end of the edge-detection path. It takes single-cycle event pulses, for example from the rising-edge detector, and turns them back into clean level pulses of programmable width. A mandatory low gap follows each output pulse, so every accepted event produces a distinct rising edge downstream. It also queues one event per channel and flags events it cannot accept.

## Interface
- CANAIS, 2: number of independent channels.
- W, 8: width of the duration field and of each channel's counter.
- PAUSA_MIN, 1: number of forced-low cycles after each output pulse; must be ≥1.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pulso  in  CANAIS  event request per channel, sampled on each rising clk edge.
- duracao  in  W  output pulse width D in cycles. The value 0 is treated as 1. Sampled on every load or reload.
- retrig  in  1  1: a new event during ALTO extends the current pulse. 0: it is queued.
- limpa_perdido  in  1  synchronous clear of every perdido bit.
- saida  out  CANAIS  stretched level output, registered.
- ocupado  out  CANAIS  channel is not OCIOSO, or has an event pending.
- perdido  out  CANAIS  sticky flag: an event was dropped on this channel.

## Operation
- Each channel has three states, a counter cnt[W-1:0] and a one-deep pendente flag.
- States:
  - OCIOSO: saida=0.
  - ALTO: saida=1.
  - PAUSA: saida=0 for exactly PAUSA_MIN cycles.
- OCIOSO with pulso=1: load cnt=D-1, go to ALTO.
- ALTO, no pulso: decrement cnt. When cnt==0, go to PAUSA and load the gap count.
- ALTO with pulso=1 and retrig=1: reload cnt=D-1 and stay in ALTO. No gap is inserted. This includes the cycle where cnt==0.
- ALTO with pulso=1 and retrig=0:
  - if pendente=0, set pendente;
  - otherwise set perdido.
  - The counter continues to decrement normally.
- PAUSA with pulso=1: set pendente, or set perdido if pendente is already 1. retrig is ignored in PAUSA.
- End of PAUSA:
  - pendente=1: clear pendente, load cnt=D-1, go to ALTO;
  - otherwise go to OCIOSO.
- limpa_perdido clears all perdido bits. A loss in the same cycle takes priority, so perdido ends that cycle at 1.
- Channels are fully independent. duracao, retrig and limpa_perdido are shared by all channels.

## Timing
- Reset: state=OCIOSO, cnt=0, pendente=0, saida=0, ocupado=0, perdido=0. These values apply immediately, even mid-pulse.
- Latency: a pulse sampled at edge k in OCIOSO gives saida=1 after edge k.
- Width: saida stays high for exactly D cycles and falls after edge k+D.
- Gap: saida stays low for exactly PAUSA_MIN cycles before any queued pulse starts.
- Retrigger at edge j: saida stays high until edge j+D.
- ocupado and perdido are registered and update on the same edge as the state.
- Maximum D is 2^W−1. The counter never wraps, because the transition at cnt==0 takes priority over the decrement.

## Structure
- Shared package estendedor_pkg holds:
  - the state typedef: 2-bit enum with OCIOSO=0, ALTO=1, PAUSA=2;
  - the function that clamps duracao=0 to 1.
- Sub-module estendedor_canal implements one channel: FSM, counter, pendente and perdido.
- The top level instantiates estendedor_canal CANAIS times with a generate loop and routes the shared inputs to every instance.

## Test plan
- Single pulse, duracao=4, retrig=0 on channel 0 -> saida[0] high exactly 4 cycles starting the edge after the pulse; ocupado[0] high 5 cycles; channel 1 stays 0.
- duracao=0 -> saida is high exactly 1 cycle.
- Two pulses 2 cycles apart, D=4, retrig=0 -> high 4 cycles, low 1 cycle, high 4 cycles; perdido=0.
- Three pulses during one ALTO, retrig=0 -> second pulse is queued, third sets perdido[0]=1; pulsing limpa_perdido later returns it to 0.
- D=3, retrig=1, pulses at cycles 0 and 2 -> saida high continuously for 5 cycles (edges 0→5) with no gap.
- rst asserted during ALTO with pendente=1 -> saida, ocupado and perdido go to 0 immediately. The next pulse after release gives a normal D-cycle output with no replayed event.
